// File: rtl/threshold_ctrl.sv
// Edge-binarisation frame controller: registered valid/ready stage, per-frame
// statistics and threshold update. Define THRESH_HYST_EN to slew-limit adaptive updates.
module threshold_ctrl #(
    parameter int DATA_W         = 8,
    parameter int LOG2_PIX       = 16,
    parameter int DEFAULT_THRESH = 100,
    parameter int HYST_STEP      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_mode,
    input  logic [DATA_W-1:0] cfg_thresh,
    input  logic [DATA_W-1:0] cfg_offset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    input  logic              s_eof,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eof,
    output logic [DATA_W-1:0] thresh_cur,
    output logic [DATA_W-1:0] thr_active,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int SUM_W = DATA_W + LOG2_PIX + 1;
    localparam int CNT_W = LOG2_PIX + 1;
    localparam logic [CNT_W-1:0]  FRAME_PIX = {1'b1, {LOG2_PIX{1'b0}}};
    localparam logic [DATA_W-1:0] MAX_V     = '1;

    typedef enum logic [1:0] {IDLE, RUN, UPDATE} state_t;

    state_t              r_state, w_next;
    logic [SUM_W-1:0]    r_sum, w_sum_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_thr_cur, r_thr_act;
    logic                r_mv, r_ms, r_me, r_done, r_err;
    logic [DATA_W-1:0]   r_md;

    logic                w_s_ready, w_acc, w_load, w_err_nxt;
    logic [DATA_W-1:0]   w_load_thr, w_cmp_thr, w_bin;
    logic [SUM_W-1:0]    w_mean_full;
    logic [DATA_W-1:0]   w_mean, w_tgt, w_adapt, w_thr_upd;
    logic [DATA_W:0]     w_tgt_full;

    assign w_s_ready  = (r_state != UPDATE) && (!r_mv || m_ready);
    assign w_acc      = s_valid && w_s_ready;
    assign w_load_thr = cfg_mode ? r_thr_cur : cfg_thresh;
    // A sof beat is binarised against the threshold it loads, not the stale one
    assign w_cmp_thr  = s_sof ? w_load_thr : r_thr_act;
    assign w_bin      = (s_data > w_cmp_thr) ? '1 : '0;

    always_comb begin
        w_next    = r_state;
        w_sum_nxt = r_sum;
        w_cnt_nxt = r_cnt;
        w_err_nxt = 1'b0;
        w_load    = 1'b0;
        case (r_state)
            IDLE, RUN: begin
                if (w_acc) begin
                    if (s_sof) begin
                        w_load    = 1'b1;
                        w_sum_nxt = SUM_W'(s_data);
                        w_cnt_nxt = CNT_W'(1);
                        w_err_nxt = (r_state == RUN);
                        w_next    = RUN;
                    end else if (r_state == RUN) begin
                        w_sum_nxt = r_sum + SUM_W'(s_data);
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                    if (s_eof && (s_sof || r_state == RUN)) begin
                        w_next = UPDATE;
                        if (w_cnt_nxt != FRAME_PIX) w_err_nxt = 1'b1;
                    end
                end
            end
            UPDATE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_mean_full = r_sum >> LOG2_PIX;
    assign w_mean      = (w_mean_full > SUM_W'(MAX_V)) ? MAX_V : w_mean_full[DATA_W-1:0];
    assign w_tgt_full  = {1'b0, w_mean} + {1'b0, cfg_offset};
    assign w_tgt       = w_tgt_full[DATA_W] ? MAX_V : w_tgt_full[DATA_W-1:0];

`ifdef THRESH_HYST_EN
    localparam logic [DATA_W-1:0] HYST_V = DATA_W'(HYST_STEP);
    logic [DATA_W:0]   w_hi_full;
    logic [DATA_W-1:0] w_hi, w_lo;

    // Window bounds saturate instead of wrapping near 0 and all-ones
    assign w_hi_full = {1'b0, r_thr_cur} + {1'b0, HYST_V};
    assign w_hi      = w_hi_full[DATA_W] ? MAX_V : w_hi_full[DATA_W-1:0];
    assign w_lo      = (r_thr_cur >= HYST_V) ? (r_thr_cur - HYST_V) : '0;
    assign w_adapt   = (w_tgt > w_hi) ? w_hi : ((w_tgt < w_lo) ? w_lo : w_tgt);
`else
    assign w_adapt   = w_tgt;
`endif

    assign w_thr_upd = cfg_mode ? w_adapt : cfg_thresh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sum     <= '0;
            r_cnt     <= '0;
            r_thr_cur <= DATA_W'(DEFAULT_THRESH);
            r_thr_act <= DATA_W'(DEFAULT_THRESH);
            r_mv      <= 1'b0;
            r_md      <= '0;
            r_ms      <= 1'b0;
            r_me      <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sum   <= w_sum_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_done  <= (r_state == UPDATE);
            if (w_load) r_thr_act <= w_load_thr;
            if (r_state == UPDATE) r_thr_cur <= w_thr_upd;
            if (w_acc) begin
                r_mv <= 1'b1;
                r_md <= w_bin;
                r_ms <= s_sof;
                r_me <= s_eof;
            end else if (m_ready) begin
                r_mv <= 1'b0;
            end
        end
    end

    assign s_ready    = w_s_ready;
    assign m_valid    = r_mv;
    assign m_data     = r_md;
    assign m_sof      = r_ms;
    assign m_eof      = r_me;
    assign thresh_cur = r_thr_cur;
    assign thr_active = r_thr_act;
    assign frame_done = r_done;
    assign frame_err  = r_err;

endmodule

// File: tb/tb_threshold_ctrl.sv
// Self-checking bench for threshold_ctrl with a 4-pixel frame; reference model
// keeps each frame's pixels in a queue and derives thresholds arithmetically.
module tb_threshold_ctrl;

    localparam int NPIX = 4;
    localparam int DEF  = 100;
    localparam int HS   = 8;
`ifdef THRESH_HYST_EN
    localparam int EXP_ADAPT = 92;
    localparam int EXP_SAT   = 100;
    localparam int EXP_HYST  = 108;
`else
    localparam int EXP_ADAPT = 80;
    localparam int EXP_SAT   = 255;
    localparam int EXP_HYST  = 200;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_mode = 1'b0;
    logic [7:0] cfg_thresh = 8'd100, cfg_offset = 8'd0;
    logic       s_valid = 1'b0, s_sof = 1'b0, s_eof = 1'b0, m_ready = 1'b1;
    logic [7:0] s_data = 8'd0;
    logic       s_ready, m_valid, m_sof, m_eof, frame_done, frame_err;
    logic [7:0] m_data, thresh_cur, thr_active;

    always #5 clk = ~clk;

    threshold_ctrl #(.DATA_W(8), .LOG2_PIX(2), .DEFAULT_THRESH(DEF), .HYST_STEP(HS)) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
        .cfg_offset(cfg_offset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_sof(s_sof), .s_eof(s_eof), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_sof(m_sof), .m_eof(m_eof), .thresh_cur(thresh_cur),
        .thr_active(thr_active), .frame_done(frame_done), .frame_err(frame_err)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int  md_cur = DEF, md_act = DEF;
    bit  md_inframe = 0, md_upd = 0;
    int  md_pix[$];
    bit  e_mv = 0, e_ms = 0, e_me = 0, e_done = 0, e_err = 0;
    int  e_md = 0;
    bit  e_rdy, o_rdy;

    function automatic int target_thresh();
        int sum = 0;
        int mean, t;
        foreach (md_pix[i]) sum += md_pix[i];
        mean = sum / NPIX;
        if (mean > 255) mean = 255;
        if (!cfg_mode) return int'(cfg_thresh);
        t = mean + int'(cfg_offset);
        if (t > 255) t = 255;
`ifdef THRESH_HYST_EN
        if (t > md_cur + HS) t = md_cur + HS;
        if (t < md_cur - HS) t = md_cur - HS;
`endif
        return t;
    endfunction

    task automatic model_edge();
        bit acc;
        int thr;
        if (rst) begin
            md_cur = DEF; md_act = DEF; md_inframe = 0; md_upd = 0; md_pix.delete();
            e_mv = 0; e_ms = 0; e_me = 0; e_done = 0; e_err = 0; e_md = 0;
            return;
        end
        acc = s_valid && !md_upd && (!e_mv || m_ready);
        e_done = 0;
        e_err  = 0;
        if (md_upd) begin
            md_cur = target_thresh();
            e_done = 1; md_upd = 0; md_inframe = 0;
        end
        if (acc) begin
            thr = md_act;
            if (s_sof) begin
                thr = cfg_mode ? md_cur : int'(cfg_thresh);
                e_err = md_inframe;
                md_act = thr;
                md_pix.delete();
                md_pix.push_back(int'(s_data));
                md_inframe = 1;
            end else if (md_inframe) begin
                md_pix.push_back(int'(s_data));
            end else begin
                e_err = 1;
            end
            e_mv = 1; e_ms = s_sof; e_me = s_eof;
            e_md = (int'(s_data) > thr) ? 255 : 0;
            if (s_eof && md_inframe) begin
                md_upd = 1;
                if (md_pix.size() != NPIX) e_err = 1;
            end
        end else if (m_ready) begin
            e_mv = 0;
        end
    endtask

    // One clock: drive at negedge, capture s_ready before the edge, step model at the edge
    task automatic cycle(input bit v, input int d, input bit sof, input bit eof, input bit mr);
        s_valid = v; s_data = 8'(d); s_sof = sof; s_eof = eof; m_ready = mr;
        #1;
        o_rdy = s_ready;
        e_rdy = !md_upd && (!e_mv || mr);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic logic [29:0] exp_vec();
        return {e_rdy, e_mv, e_ms, e_me, e_done, e_err, 8'(e_md), 8'(md_cur), 8'(md_act)};
    endfunction

    function automatic logic [29:0] obs_vec();
        return {o_rdy, m_valid, m_sof, m_eof, frame_done, frame_err, m_data, thresh_cur, thr_active};
    endfunction

    task automatic test_reset();
        rst = 1;
        cycle(1, $urandom_range(0, 255), 1, 0, 1);
        cycle(1, $urandom_range(0, 255), 1, 1, 0);
        rst = 0;
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset: got %h expected %h", obs_vec(), exp_vec());
        end
        vectors++;
        if ({m_valid, frame_done, frame_err, thresh_cur, thr_active} !== {3'b000, 8'd100, 8'd100}) begin
            miscompares++;
            $display("FAIL reset_values: got mv=%b done=%b err=%b cur=%0d act=%0d expected 0 0 0 100 100",
                     m_valid, frame_done, frame_err, thresh_cur, thr_active);
        end
    endtask

    task automatic test_fixed();
        int beats[4] = '{99, 100, 101, 255};
        int lit[4]   = '{0, 0, 255, 255};
        cfg_mode = 0; cfg_thresh = 8'd100;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) cycle(1, beats[i], i == 0, i == 3, 1);
            else       cycle(0, 0, 0, 0, 1);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL fixed[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i < 4) begin
                vectors++;
                if ({m_valid, m_sof, m_data} !== {1'b1, i == 0, 8'(lit[i])}) begin
                    miscompares++;
                    $display("FAIL fixed_data[%0d]: got v=%b sof=%b %h expected 1 %0d %h",
                             i, m_valid, m_sof, m_data, i == 0, 8'(lit[i]));
                end
            end
        end
    endtask

    task automatic test_adaptive();
        int beats[4] = '{40, 60, 80, 100};
        cfg_mode = 1; cfg_offset = 8'd10;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) cycle(1, beats[i], i == 0, i == 3, 1);
            else       cycle(0, 0, 0, 0, 1);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL adaptive[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i == 4) begin
                vectors++;
                if ({frame_done, frame_err, thresh_cur} !== {2'b10, 8'(EXP_ADAPT)}) begin
                    miscompares++;
                    $display("FAIL adaptive_update: got done=%b err=%b cur=%0d expected 1 0 %0d",
                             frame_done, frame_err, thresh_cur, EXP_ADAPT);
                end
            end
        end
    endtask

    task automatic test_saturate();
        cfg_mode = 1; cfg_offset = 8'd50;
        for (int i = 0; i < 9; i++) begin
            if (i < 4)      cycle(1, 255, i == 0, i == 3, 1);
            else if (i < 6) cycle(0, 0, 0, 0, 1);
            else            cycle(1, 255, i == 6, 0, 1);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL saturate[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i == 0 || i == 6) begin
                vectors++;
                if (thr_active !== 8'(i == 0 ? EXP_ADAPT : EXP_SAT)) begin
                    miscompares++;
                    $display("FAIL saturate_active[%0d]: got %0d expected %0d", i, thr_active,
                             i == 0 ? EXP_ADAPT : EXP_SAT);
                end
            end
            if (i == 6) begin
                vectors++;
                if (m_data !== ((EXP_SAT < 255) ? 8'hFF : 8'h00)) begin
                    miscompares++;
                    $display("FAIL saturate_data: got %h expected %h", m_data,
                             (EXP_SAT < 255) ? 8'hFF : 8'h00);
                end
            end
        end
        // close the partial frame cleanly
        for (int i = 0; i < 5; i++) begin
            if (i < 3) cycle(1, 7, 0, i == 2, 1);
            else       cycle(0, 0, 0, 0, 1);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL saturate_tail[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        int bp[11][5] = '{'{1, 30, 1, 0, 1}, '{1, 200, 0, 0, 0}, '{1, 200, 0, 0, 0},
                          '{1, 200, 0, 0, 0}, '{1, 200, 0, 0, 0}, '{1, 200, 0, 0, 0},
                          '{1, 200, 0, 0, 1}, '{1, 120, 0, 0, 1}, '{1, 250, 0, 1, 1},
                          '{0, 0, 0, 0, 1},   '{0, 0, 0, 0, 1}};
        int idx = 0;
        int lows = 0;
        cfg_mode = 0; cfg_thresh = 8'd128;
        for (int i = 0; i < 11; i++) begin
            cycle(bp[i][0] != 0, bp[i][1], bp[i][2] != 0, bp[i][3] != 0, bp[i][4] != 0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL backpressure[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        for (int c = 0; c < 40 && idx < 12; c++) begin
            cycle(1, $urandom_range(0, 255), (idx % 4) == 0, (idx % 4) == 3, 1);
            if (o_rdy) idx++;
            else lows++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL full_rate[%0d]: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (idx != 12 || lows != 2) begin
            miscompares++;
            $display("FAIL full_rate_bubbles: got beats=%0d stalls=%0d expected 12 2", idx, lows);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 0, 0, 1);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL full_rate_tail[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_framing();
        int fr[15][4] = '{'{1, 10, 1, 0}, '{1, 20, 0, 0}, '{1, 30, 1, 0}, '{1, 40, 0, 0},
                          '{1, 50, 0, 0}, '{1, 160, 0, 1}, '{0, 0, 0, 0}, '{1, 70, 1, 0},
                          '{1, 80, 0, 0}, '{1, 90, 0, 1}, '{0, 0, 0, 0}, '{1, 200, 0, 0},
                          '{1, 50, 1, 1}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        int errs = 0;
        int dones = 0;
        cfg_mode = 0; cfg_thresh = 8'd100;
        for (int i = 0; i < 15; i++) begin
            cycle(fr[i][0] != 0, fr[i][1], fr[i][2] != 0, fr[i][3] != 0, 1);
            errs  += int'(frame_err);
            dones += int'(frame_done);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL framing[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i == 11) begin
                vectors++;
                if ({m_valid, m_data, frame_err} !== {1'b1, 8'hFF, 1'b1}) begin
                    miscompares++;
                    $display("FAIL idle_stray: got v=%b %h err=%b expected 1 ff 1", m_valid, m_data, frame_err);
                end
            end
        end
        vectors++;
        if (errs != 4 || dones != 3) begin
            miscompares++;
            $display("FAIL framing_counts: got err=%0d done=%0d expected 4 3", errs, dones);
        end
    endtask

    task automatic test_hyst();
        rst = 1;
        cycle(0, 0, 0, 0, 1);
        rst = 0;
        cfg_mode = 1; cfg_offset = 8'd10;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) cycle(1, 190, i == 0, i == 3, 1);
            else       cycle(0, 0, 0, 0, 1);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL hyst[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        vectors++;
        if (thresh_cur !== 8'(EXP_HYST)) begin
            miscompares++;
            $display("FAIL hyst_target: got %0d expected %0d", thresh_cur, EXP_HYST);
        end
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 6; i++) begin
            rst = (i == 2);
            if (i < 3)       cycle(1, 20 * (i + 1), i == 0, 0, 1);
            else if (i == 3) cycle(1, 240, 0, 0, 1);
            else             cycle(0, 0, 0, 0, 1);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL reset_mid[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i == 2) begin
                vectors++;
                if ({m_valid, thresh_cur, thr_active} !== {1'b0, 8'd100, 8'd100}) begin
                    miscompares++;
                    $display("FAIL reset_mid_values: got v=%b cur=%0d act=%0d expected 0 100 100",
                             m_valid, thresh_cur, thr_active);
                end
            end
        end
        rst = 0;
    endtask

    task automatic test_random();
        int d;
        bit sof, eof;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                cfg_mode   = 1'($urandom);
                cfg_thresh = 8'($urandom);
                cfg_offset = 8'($urandom_range(0, 80));
            end
            d = ($urandom_range(0, 3) == 0) ? md_act + $urandom_range(0, 2) - 1 : $urandom_range(0, 255);
            if (d < 0) d = 0;
            if (d > 255) d = 255;
            sof = md_inframe ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 5) != 0);
            if (md_pix.size() >= 5)      eof = 1;
            else if (md_pix.size() >= 3) eof = 1'($urandom);
            else                         eof = ($urandom_range(0, 9) == 0);
            cycle($urandom_range(0, 3) != 0, d, sof, eof, $urandom_range(0, 3) != 0);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h expected %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fixed();
        test_adaptive();
        test_saturate();
        test_back_to_back();
        test_framing();
        test_hyst();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/threshold_ctrl.md
Name: threshold_ctrl

Overview:
- Frame-level controller for the edge-binarisation stage; sits between the edge-magnitude stream and downstream face-detection logic.
- Sequences pixel frames through a registered valid/ready stage and binarises each pixel against the active threshold: edge > threshold gives 8'hFF, otherwise 8'h00.
- Accumulates edge statistics per frame. In adaptive mode it recomputes the threshold at end of frame; in fixed mode it uses a software-supplied value.

Parameters:
- DATA_W, 8, edge/pixel width.
- LOG2_PIX, 16, log2 of pixels per frame (default 256x256).
- DEFAULT_THRESH, 100, threshold after reset.
- HYST_STEP, 8, max per-frame threshold change (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_mode  in  1  0 = fixed (cfg_thresh), 1 = adaptive.
- cfg_thresh  in  DATA_W  fixed-mode threshold.
- cfg_offset  in  DATA_W  unsigned offset added to frame mean in adaptive mode.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  DATA_W  edge magnitude.
- s_sof  in  1  first pixel of frame.
- s_eof  in  1  last pixel of frame.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_W  binarised pixel.
- m_sof  out  1  sof passed through.
- m_eof  out  1  eof passed through.
- thresh_cur  out  DATA_W  threshold to be applied from the next frame.
- thr_active  out  DATA_W  threshold applied to the current frame.
- frame_done  out  1  one-cycle pulse after each threshold update.
- frame_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset values: thresh_cur and thr_active = DEFAULT_THRESH; m_valid, m_data, m_sof, m_eof, frame_done, frame_err = 0; state = IDLE; sum and pix_cnt = 0.
- Output stage: single register. s_ready = (state != UPDATE) && (!m_valid || m_ready).
  - Accepted beat appears on m_* the next cycle.
  - m_* held stable while m_valid && !m_ready.
  - Zero bubbles at full throughput.
- Compare: m_data = (s_data > thr_active) ? all-ones : 0. Strict greater-than, so s_data == thr_active gives 0.
- Accumulators:
  - sum is DATA_W+LOG2_PIX+1 bits; adds s_data on every accepted beat in RUN (including the sof and eof beats).
  - pix_cnt is LOG2_PIX+1 bits.
- IDLE state:
  - Accepted beat with s_sof: load thr_active from cfg_thresh if cfg_mode=0, else from thresh_cur. The beat is compared against the newly loaded value. sum = s_data, pix_cnt = 1, go to RUN.
  - Accepted beat without s_sof: passed through binarised with the current thr_active, not counted, frame_err pulses.
- RUN state:
  - Accepted beat: sum += s_data, pix_cnt += 1.
  - Accepted s_sof: frame_err pulses; accumulation restarts with this beat as first (sum = s_data, pix_cnt = 1); thr_active reloads.
  - Accepted s_eof: go to UPDATE. If the incremented pix_cnt != 2^LOG2_PIX, frame_err pulses (on the same cycle as the eof acceptance), but the update still occurs.
  - A beat with both s_sof and s_eof is a one-pixel frame: the sof action is taken, then go to UPDATE.
- UPDATE state (exactly 1 cycle, s_ready = 0):
  - mean = sum >> LOG2_PIX, saturated to 2^DATA_W-1.
  - Adaptive: thresh_cur = min(mean + cfg_offset, 2^DATA_W-1).
  - Fixed: thresh_cur = cfg_thresh.
  - frame_done pulses; next state IDLE.
- The threshold never changes mid-frame. cfg_* changes take effect only at the next sof acceptance or update.
- rst mid-frame: the in-flight m_* beat is dropped, the frame is abandoned, and all values return to their reset values.

Optional Feature:
- Macro THRESH_HYST_EN.
- Defined: in adaptive mode, the UPDATE target is clamped to thresh_cur ± HYST_STEP (no wrap: lower bound 0, upper bound all-ones).
- Undefined: thresh_cur takes the target directly. HYST_STEP is unused.

Test Plan:
- Fixed mode, cfg_thresh=100; beats 99, 100, 101, 255 (sof on first) -> m_data 00, 00, FF, FF in order, one-cycle latency, m_sof on first output.
- Adaptive, LOG2_PIX=2, cfg_offset=10; frame 40, 60, 80, 100 with sof/eof -> sum 280, mean 70, thresh_cur=80, frame_done 1 cycle after eof acceptance, frame_err=0; next frame thr_active=80.
- Adaptive, frame of all 255 with cfg_offset=50 -> thresh_cur saturates at 255; next frame input 255 -> 00.
- Backpressure: hold m_ready=0 for 5 cycles mid-frame -> s_ready=0, m_data/m_sof/m_eof stable, no beat lost or duplicated; full-rate stream with m_ready=1 -> s_ready low only in the UPDATE cycle.
- Framing: second sof after 2 beats (LOG2_PIX=2) -> frame_err pulse, count restarts; eof after 3 beats -> frame_err pulse and update still occurs; beat without sof in IDLE -> frame_err pulse, beat passed through binarised with current thr_active.
- THRESH_HYST_EN defined, HYST_STEP=8, thresh_cur=100, target 200 -> thresh_cur=108; rst asserted mid-frame -> thresh_cur=100, m_valid=0 next cycle.
